// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - Round-robin owner of the shared L2 port for the I-cache (0) and D-cache (1)
// Optional BUSY watchdog with sticky timeout_err enabled by L2_TIMEOUT_EN.
module l2_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req0,
    input  logic              wr_req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              rd_req1,
    input  logic              wr_req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              l2_ack,
    input  logic              write_done,
    output logic              l2_rd,
    output logic              l2_wr,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              ack0,
    output logic              ack1,
    output logic              wdone0,
    output logic              wdone1,
    output logic              gnt,
    output logic [1:0]        state
`ifdef L2_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   prio_q, prio_d;
    logic   active0, active1;
    logic   busy, sel_rd, sel_wr;
    logic   ack_end, abandon, expire;

    assign active0 = rd_req0 | wr_req0;
    assign active1 = rd_req1 | wr_req1;
    assign busy    = (state_q == BUSY);
    assign sel_rd  = gnt_q ? rd_req1 : rd_req0;
    assign sel_wr  = gnt_q ? wr_req1 : wr_req0;

    // Write-back wins if the owner ever drives both, so l2_rd/l2_wr stay exclusive.
    assign l2_wr   = busy & sel_wr;
    assign l2_rd   = busy & sel_rd & ~sel_wr;
    assign l2_addr = busy ? (gnt_q ? addr1 : addr0) : '0;

    assign ack0    = busy & ~gnt_q & l2_ack;
    assign ack1    = busy &  gnt_q & l2_ack;
    assign wdone0  = busy & ~gnt_q & write_done;
    assign wdone1  = busy &  gnt_q & write_done;

    assign ack_end = l2_ack & l2_rd;
    assign abandon = ~(gnt_q ? active1 : active0);

    assign gnt     = gnt_q;
    assign state   = state_q;

`ifdef L2_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Counter reads 0 on the first BUSY cycle, so the abort fires on BUSY cycle TIMEOUT.
    assign expire = busy & (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= busy ? cnt_q + 1'b1 : '0;
            if (expire & ~ack_end & ~abandon) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (active0 | active1) begin
                    gnt_d   = (active0 & active1) ? prio_q : active1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ack_end) begin
                    state_d = DONE;
                    prio_d  = ~gnt_q;
                end else if (abandon | expire) begin
                    state_d = IDLE;
                    prio_d  = ~gnt_q;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 request port between two L1 cache controllers: requester 0 = I-cache, requester 1 = D-cache.
- Sits between the two cache_controller instances and the L2 model.
- Grants one requester at a time, using round-robin priority.
- Holds the grant across a complete miss: optional write-back, then the allocate read.
- Routes l2_ack and write_done only to the granted requester.

Parameters:
ADDR_W, 32, address width forwarded to L2
TIMEOUT, 255, cycles before watchdog abort (used only with L2_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_req0  in  1  read_l2 from requester 0
wr_req0  in  1  write_l2 from requester 0
addr0  in  ADDR_W  address from requester 0
rd_req1  in  1  read_l2 from requester 1
wr_req1  in  1  write_l2 from requester 1
addr1  in  ADDR_W  address from requester 1
l2_ack  in  1  L2 read data ready
write_done  in  1  L2 write-back complete
l2_rd  out  1  read request to L2
l2_wr  out  1  write request to L2
l2_addr  out  ADDR_W  address to L2
ack0  out  1  l2_ack routed to requester 0
ack1  out  1  l2_ack routed to requester 1
wdone0  out  1  write_done routed to requester 0
wdone1  out  1  write_done routed to requester 1
gnt  out  1  current grant owner, registered
state  out  2  FSM state, for debug

Behaviour:
- Requester i is "active" when rd_reqi | wr_reqi.
- FSM states: IDLE=2'b00, BUSY=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
- Reset (reset=0, async) forces:
  - state=IDLE, gnt=0, prio=0 (prio is the internal next-preferred requester);
  - all outputs 0, l2_addr=0.
- IDLE:
  - Sample both active flags each cycle.
  - If exactly one is active, grant it.
  - If both are active, grant prio.
  - On a grant: gnt<=winner, state<=BUSY. Effect is visible the cycle after the request; arbitration latency is 1 cycle.
- BUSY:
  - l2_rd = rd_req[gnt], l2_wr = wr_req[gnt], l2_addr = addr[gnt]. These are combinational from the registered gnt; the loser's signals are ignored.
  - ack[gnt] = l2_ack and wdone[gnt] = write_done. The non-granted ack/wdone are always 0.
  - Dirty miss: wr_req drops and rd_req rises with no idle gap (WB to ALLOCATE). The grant is held.
  - l2_ack while l2_rd=1 ends the transaction: state<=DONE, prio<=~gnt.
  - Granted requester becomes inactive with no l2_ack (abandoned): state<=IDLE, prio<=~gnt.
  - write_done alone does not end the transaction.
- DONE:
  - Lasts exactly 1 cycle; no L2 outputs are asserted.
  - Lets the finished controller leave ALLOCATE before it is re-sampled.
  - state<=IDLE.
- The outgoing l2_rd and l2_wr are never both 1.
- l2_ack or write_done arriving in IDLE or DONE is dropped; no ack/wdone pulse is produced.
- Reset asserted mid-BUSY aborts immediately. L2 sees l2_rd/l2_wr fall asynchronously.
- Fairness: with both requesters continuously active, grants alternate 0,1,0,1.

Optional Feature:
- Macro: L2_TIMEOUT_EN.
- Defined:
  - An 8-bit-min counter (width $clog2(TIMEOUT+1)) clears on entering BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT with no ending condition: state<=IDLE, prio<=~gnt, and a sticky output port timeout_err (1 bit) is set.
  - timeout_err is cleared only by reset.
- Not defined: no counter and no timeout_err port; BUSY waits indefinitely.

Test Plan:
1. Single read: rd_req1=1, addr1=32'h0000_5800 from IDLE.
   - Next cycle: gnt=1, state=01, l2_rd=1, l2_addr=32'h0000_5800.
   - L2 pulses l2_ack after 3 cycles: ack1=1 that cycle, ack0=0; then state=10, then 00.
2. Dirty miss, requester 0: wr_req0=1 for 4 cycles; write_done=1; then wr_req0=0, rd_req0=1; l2_ack.
   - gnt stays 0 throughout and l2_wr→l2_rd switch is seamless.
   - wdone0 pulses with write_done; state stays 01 until l2_ack.
3. Simultaneous requests after reset: rd_req0=rd_req1=1.
   - gnt=0 first (prio=0).
   - After l2_ack, DONE, IDLE, then gnt=1 with l2_addr=addr1.
   - Requester 0 re-requesting immediately still waits for requester 1.
4. Misrouting check: requester 1 waits while 0 is granted.
   - Every l2_ack/write_done pulse appears only on ack0/wdone0; ack1/wdone1 remain 0.
5. Reset mid-BUSY: drop reset for 1 cycle during l2_rd=1.
   - l2_rd=0, state=00, gnt=0 immediately.
   - Stray l2_ack afterwards produces no ack pulse.
6. With L2_TIMEOUT_EN, TIMEOUT=8: rd_req0 held with no l2_ack.
   - After 8 BUSY cycles: state=00 and timeout_err=1.
   - Pending rd_req1 is granted next.
